fsk_byte_framer: RTL and testbench
==================================

// Module: fsk_byte_framer
// PURPOSE
//  Pops bytes from the UART receive FIFO and frames each one as start bit, 8 data bits (LSB first) and stop bit.
//  Each bit is held for one bit period, and the frame is mapped to a 12-bit tone step on `select`.
//  Sits between top_uart (r_data/rx_empty/rd_uart) and sin_data (select); replaces the free-running bit-rate stage.
//  Line idles at mark tone.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency
//  BIT_HZ      1_000       FSK bit rate; DIV = CLK_HZ/BIT_HZ clocks per bit, DIV >= 2 required
//  STEP_MARK   12'd40      select value for logic 1 / idle / stop
//  STEP_SPACE  12'd20      select value for logic 0 / start
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  reset       in   1   synchronous, active-high reset
//  enable      in   1   1 = allowed to start new frames
//  rx_empty    in   1   UART FIFO empty flag
//  r_data      in   8   UART FIFO head word, valid while rx_empty=0 (first-word-fall-through)
//  rd_uart     out  1   one-cycle pop strobe to UART FIFO
//  select      out  12  tone step to sin_data, registered
//  tx_bit      out  1   current line bit (debug/loopback)
//  bit_strobe  out  1   one-cycle pulse on first clock of every bit period
//  busy        out  1   1 while a frame is in progress
// BEHAVIOUR
//  Reset values (checked on the cycle after reset is sampled high):
//   - state=IDLE, select=STEP_MARK, tx_bit=1, rd_uart=0, bit_strobe=0, busy=0, counters=0.
//  FSM states: IDLE, START, DATA, STOP.
//  IDLE:
//   - If enable=1 and rx_empty=0: rd_uart=1 for exactly that cycle; latch r_data into shift reg in the same cycle.
//   - Next state is START. Otherwise stay in IDLE, rd_uart=0.
//  START: tx_bit=0 for DIV clocks, then DATA with bit index 0.
//  DATA: tx_bit=shreg[0] for DIV clocks; then shift right and increment index; after index 7 go to STOP.
//  STOP: tx_bit=1 for DIV clocks, then IDLE.
//  Bit timer:
//   - Counter width $clog2(DIV); clears on every state entry; terminal count DIV-1 advances the bit.
//   - bit_strobe=1 on count==0 in START/DATA/STOP.
//  Output mapping and latency:
//   - select = tx_bit ? STEP_MARK : STEP_SPACE, registered in the same cycle as tx_bit.
//   - First START cycle (select=STEP_SPACE) is the clock after the rd_uart cycle.
//  Frame length: exactly 10*DIV clocks of busy=1; busy=0 only in IDLE.
//  Back-to-back bytes: one IDLE clock between STOP end and the next rd_uart; gap is 1 clock at mark.
//  Empty FIFO: never pop while rx_empty=1; stays IDLE at mark indefinitely.
//  enable=0 mid-frame: current frame completes normally; no new pop until enable=1.
//  Reset mid-frame: next cycle IDLE with reset values; the partially sent byte is dropped, no extra pop.
//  rx_empty/r_data are sampled only in IDLE; changes during a frame are ignored.
// STRUCTURE
//  Package fsk_pkg:
//   - state encoding localparams (IDLE/START/DATA/STOP, 2 bits)
//   - default STEP_MARK/STEP_SPACE
//   - function computing DIV and counter width
//  Sub-module fsk_bit_timer (clk, reset, clear, tick_first, tick_last):
//   - prescaler shared with a future demodulator; rest of the FSM is inline.
// TESTING  (bench params CLK_HZ=1000, BIT_HZ=100 -> DIV=10)
//  1. Reset held 3 cycles:
//     -> select=STEP_MARK, tx_bit=1, rd_uart=0, busy=0; stays so with rx_empty=1 for 200 cycles.
//  2. One byte 0xA5, FIFO non-empty:
//     -> single rd_uart pulse.
//     -> tx_bit sequence 0,1,0,1,0,0,1,0,1,1, each held 10 clocks.
//     -> busy=1 for 100 clocks; 10 bit_strobe pulses.
//  3. Bytes 0x00 then 0xFF queued:
//     -> second rd_uart exactly 1 clock after first frame's STOP ends.
//     -> 0x00 frame: 9 space bits then mark; 0xFF frame: start space then 9 mark bits.
//  4. Reset asserted during data bit 4 of 0x3C:
//     -> next cycle IDLE/mark, busy=0.
//     -> no rd_uart while reset held; new pop only after release if FIFO non-empty.
//  5. enable dropped at START of 0x55:
//     -> full 100-clock frame still sent; no further rd_uart with FIFO non-empty until enable=1.
//  6. r_data toggled randomly during a frame:
//     -> transmitted bits match the byte latched at the rd_uart cycle.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared types and helpers for the FSK byte framer: state encoding, default tone
// steps and bit-period sizing.
package fsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [11:0] STEP_MARK_DEF  = 12'd40;
    localparam logic [11:0] STEP_SPACE_DEF = 12'd20;

    function automatic int fsk_div(input int clk_hz, input int bit_hz);
        return clk_hz / bit_hz;
    endfunction

    // A one-bit counter is the floor so DIV=2 still gets a usable register.
    function automatic int fsk_cnt_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/fsk_bit_timer.sv
// Bit-period prescaler: counts 0..DIV-1 and flags the first and last clock of each
// bit. Held at zero while clear is high so every bit starts from a fresh count.
module fsk_bit_timer #(
    parameter int DIV = 10,
    parameter int CW  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick_first,
    output logic tick_last
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Wrapping on the terminal count restarts the count at the entry of the next bit.
    always_ff @(posedge clk) begin
        if (reset || clear)
            r_cnt <= '0;
        else if (r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign tick_first = (r_cnt == '0);
    assign tick_last  = (r_cnt == LAST);

endmodule

// File: rtl/fsk_byte_framer.sv
// Pops bytes from a FWFT UART FIFO and sends each as start, 8 data bits LSB first and
// stop, mapping the line bit to a mark/space tone step for the sine generator.
module fsk_byte_framer
    import fsk_pkg::*;
#(
    parameter int          CLK_HZ     = 50_000_000,
    parameter int          BIT_HZ     = 1_000,
    parameter logic [11:0] STEP_MARK  = STEP_MARK_DEF,
    parameter logic [11:0] STEP_SPACE = STEP_SPACE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd_uart,
    output logic [11:0] select,
    output logic        tx_bit,
    output logic        bit_strobe,
    output logic        busy
);

    localparam int DIV = fsk_div(CLK_HZ, BIT_HZ);
    localparam int CW  = fsk_cnt_w(DIV);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_shreg, w_shreg_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic        r_tx_bit, w_tx_nxt;
    logic [11:0] r_select;
    logic        w_pop, w_tick_first, w_tick_last, w_clear;

    assign w_clear = (r_state == ST_IDLE);

    fsk_bit_timer #(.DIV(DIV), .CW(CW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_clear),
        .tick_first (w_tick_first),
        .tick_last  (w_tick_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && !rx_empty) begin
                    w_pop       = 1'b1;
                    w_shreg_nxt = r_data;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_tick_last) begin
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick_last) begin
                    w_shreg_nxt = {1'b0, r_shreg[7:1]};
                    if (r_idx == 3'd7)
                        w_state_nxt = ST_STOP;
                    else
                        w_idx_nxt = r_idx + 3'd1;
                end
            end
            ST_STOP: begin
                if (w_tick_last)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Line bit is computed for the upcoming state so tx_bit/select align with it.
        case (w_state_nxt)
            ST_START: w_tx_nxt = 1'b0;
            ST_DATA:  w_tx_nxt = w_shreg_nxt[0];
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= 3'd0;
            r_tx_bit <= 1'b1;
            r_select <= STEP_MARK;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_tx_bit <= w_tx_nxt;
            r_select <= w_tx_nxt ? STEP_MARK : STEP_SPACE;
        end
    end

    always_ff @(posedge clk) begin
        r_shreg <= w_shreg_nxt;
    end

    assign rd_uart    = w_pop && !reset;
    assign select     = r_select;
    assign tx_bit     = r_tx_bit;
    assign busy       = (r_state != ST_IDLE);
    assign bit_strobe = busy && w_tick_first;

endmodule

// File: tb/tb_fsk_byte_framer.sv
// Directed, table-driven bench for fsk_byte_framer at DIV=10 (CLK_HZ=1000, BIT_HZ=100).
module tb_fsk_byte_framer;

    localparam logic [11:0] MARK  = 12'd40;
    localparam logic [11:0] SPACE = 12'd20;

    logic        clk = 1'b0;
    logic        reset, enable, rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart, tx_bit, bit_strobe, busy;
    logic [11:0] select;

    fsk_byte_framer #(
        .CLK_HZ     (1000),
        .BIT_HZ     (100),
        .STEP_MARK  (MARK),
        .STEP_SPACE (SPACE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .rd_uart    (rd_uart),
        .select     (select),
        .tx_bit     (tx_bit),
        .bit_strobe (bit_strobe),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Inputs apply during one cycle; x_rd is rd_uart within that cycle, the rest are
    // the outputs seen after the clock edge that ends it.
    typedef struct {
        logic        rst, en, emp;
        logic [7:0]  d;
        logic        x_rd, x_tx, x_busy, x_stb;
        logic [11:0] x_sel;
        string       tag;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input int idx, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add_idle(input int n, input logic rst, input logic en, input logic emp, input string tag);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.rst = rst; v.en = en; v.emp = emp; v.d = 8'h00;
            v.x_rd = 1'b0; v.x_tx = 1'b1; v.x_busy = 1'b0; v.x_stb = 1'b0; v.x_sel = MARK;
            v.tag = tag;
            vq.push_back(v);
        end
    endtask

    // pat[9] is the first bit on the line (start), pat[0] the stop bit.
    task automatic add_frame(input logic [7:0] byt, input logic [9:0] pat, input logic en_f,
                             input logic emp_f, input logic rnd, input int len, input string tag);
        vec_t v;
        int   c;
        v.rst = 1'b0; v.en = 1'b1; v.emp = 1'b0; v.d = byt; v.tag = tag;
        v.x_rd = 1'b1; v.x_tx = pat[9]; v.x_busy = 1'b1; v.x_stb = 1'b1;
        v.x_sel = pat[9] ? MARK : SPACE;
        vq.push_back(v);
        for (int j = 0; j < len; j++) begin
            c = j + 1;
            v.en  = en_f;
            v.emp = rnd ? 1'($urandom_range(0, 1)) : emp_f;
            v.d   = rnd ? 8'($urandom_range(0, 255)) : byt;
            v.x_rd = 1'b0;
            if (c < 100) begin
                v.x_tx   = pat[9 - c / 10];
                v.x_busy = 1'b1;
                v.x_stb  = ((c % 10) == 0);
            end else begin
                v.x_tx   = 1'b1;
                v.x_busy = 1'b0;
                v.x_stb  = 1'b0;
            end
            v.x_sel = v.x_tx ? MARK : SPACE;
            vq.push_back(v);
        end
    endtask

    initial begin
        int busy_n, stb_n, pops;
        reset = 1'b1; enable = 1'b0; rx_empty = 1'b1; r_data = 8'h00;

        // 1: reset then long idle with empty FIFO
        add_idle(3,   1'b1, 1'b1, 1'b1, "reset");
        add_idle(200, 1'b0, 1'b1, 1'b1, "idle_empty");
        // 2: single byte 0xA5
        add_frame(8'hA5, 10'b0101001011, 1'b1, 1'b1, 1'b0, 100, "a5");
        add_idle(5, 1'b0, 1'b1, 1'b1, "after_a5");
        // 3: back-to-back 0x00 then 0xFF, second pop on the single idle clock
        add_frame(8'h00, 10'b0000000001, 1'b1, 1'b0, 1'b0, 100, "x00");
        add_frame(8'hFF, 10'b0111111111, 1'b1, 1'b1, 1'b0, 100, "xff");
        add_idle(3, 1'b0, 1'b1, 1'b1, "after_ff");
        // 4: reset during data bit 4 of 0x3C, then re-pop after release
        add_frame(8'h3C, 10'b0001111001, 1'b1, 1'b0, 1'b0, 55, "x3c_cut");
        add_idle(4, 1'b1, 1'b1, 1'b0, "mid_reset");
        add_frame(8'h3C, 10'b0001111001, 1'b1, 1'b1, 1'b0, 100, "x3c_full");
        add_idle(2, 1'b0, 1'b1, 1'b1, "after_3c");
        // 5: enable dropped at START of 0x55, FIFO stays non-empty
        add_frame(8'h55, 10'b0101010101, 1'b0, 1'b0, 1'b0, 100, "x55_noen");
        add_idle(20, 1'b0, 1'b0, 1'b0, "hold_en0");
        add_frame(8'h55, 10'b0101010101, 1'b1, 1'b1, 1'b0, 100, "x55_en");
        // 6: r_data/rx_empty churn during a 0xC3 frame
        add_frame(8'hC3, 10'b0110000111, 1'b1, 1'b1, 1'b1, 100, "xc3_rnd");
        add_idle(3, 1'b0, 1'b1, 1'b1, "tail");

        for (int i = 0; i < vq.size(); i++) begin
            reset = vq[i].rst; enable = vq[i].en; rx_empty = vq[i].emp; r_data = vq[i].d;
            #1;
            chk({vq[i].tag, ".rd_uart"}, i, 12'(rd_uart), 12'(vq[i].x_rd));
            @(posedge clk); #1;
            chk({vq[i].tag, ".tx_bit"},     i, 12'(tx_bit),     12'(vq[i].x_tx));
            chk({vq[i].tag, ".busy"},       i, 12'(busy),       12'(vq[i].x_busy));
            chk({vq[i].tag, ".bit_strobe"}, i, 12'(bit_strobe), 12'(vq[i].x_stb));
            chk({vq[i].tag, ".select"},     i, select,          vq[i].x_sel);
        end

        // Frame totals for one byte measured over a bounded window
        busy_n = 0; stb_n = 0; pops = 0;
        reset = 1'b0; enable = 1'b1; rx_empty = 1'b0; r_data = 8'h81;
        #1;
        if (rd_uart) pops++;
        @(posedge clk); #1;
        rx_empty = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (busy) busy_n++;
            if (bit_strobe) stb_n++;
            if (rd_uart) pops++;
            @(posedge clk); #1;
        end
        chk("total.busy_clocks", 0, 12'(busy_n), 12'd100);
        chk("total.bit_strobes", 0, 12'(stb_n),  12'd10);
        chk("total.pops",        0, 12'(pops),   12'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
